// File: rtl/lli2cs_pkg.sv
// Shared definitions for the lli2cs I2C target engine: FSM state encodings,
// the SCL-stretch setup counter width and a small shift helper.
package lli2cs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_AACK   = 4'd2,
    ST_RXBIT  = 4'd3,
    ST_RXACK  = 4'd4,
    ST_TXWAIT = 4'd5,
    ST_TXBIT  = 4'd6,
    ST_TXACK  = 4'd7,
    ST_IGNORE = 4'd8
  } state_t;

  // Width of the counter that times SDA setup before SCL is released
  localparam int SETUP_CNT_W = 8;

  // Shift one bus bit into the LSB of a byte (bits arrive MSB first)
  function automatic logic [7:0] shift_in(input logic [7:0] byte_v, input logic bit_v);
    return {byte_v[6:0], bit_v};
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: synchronises the asynchronous SCL/SDA pads, keeps one
// history sample per line and decodes SCL edges plus START/STOP conditions.
module i2c_bus_sync
  import lli2cs_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise_s,
  output logic scl_fall_s,
  output logic start_s,
  output logic stop_s
);

  logic scl_meta_r, scl_ck_r, scl_lst_r;
  logic sda_meta_r, sda_ck_r, sda_lst_r;
  logic sda_rise_s, sda_fall_s;

  // Two-flop synchronisers plus a history flop per line; idle bus level is 1
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scl_meta_r <= 1'b1;
      scl_ck_r   <= 1'b1;
      scl_lst_r  <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_ck_r   <= 1'b1;
      sda_lst_r  <= 1'b1;
    end else begin
      scl_meta_r <= i_scl;
      scl_ck_r   <= scl_meta_r;
      scl_lst_r  <= scl_ck_r;
      sda_meta_r <= i_sda;
      sda_ck_r   <= sda_meta_r;
      sda_lst_r  <= sda_ck_r;
    end
  end

  assign scl_s      = scl_ck_r;
  assign sda_s      = sda_ck_r;
  assign scl_rise_s =  scl_ck_r & ~scl_lst_r;
  assign scl_fall_s = ~scl_ck_r &  scl_lst_r;
  assign sda_rise_s =  sda_ck_r & ~sda_lst_r;
  assign sda_fall_s = ~sda_ck_r &  sda_lst_r;
  // SDA may only change while SCL is low, so an SDA edge with SCL steady high is a bus condition
  assign start_s    = scl_ck_r & scl_lst_r & sda_fall_s;
  assign stop_s     = scl_ck_r & scl_lst_r & sda_rise_s;

endmodule

// File: rtl/lli2cs.sv
// lli2cs: byte-wise I2C target engine. Matches a 7-bit address, ACKs and
// delivers write bytes, requests read bytes from the host while stretching SCL.
module lli2cs
  import lli2cs_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR     = 7'h50,
  parameter int         SETUP_CLOCKS = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl,
  output logic       o_sda,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_rx_stb,
  output logic       o_rx_first,
  output logic [7:0] o_rx_data,
  output logic       o_tx_req,
  input  logic       i_tx_stb,
  input  logic [7:0] i_tx_data,
  output logic       o_busy
);

  localparam logic [SETUP_CNT_W-1:0] SETUP_LAST = SETUP_CNT_W'(SETUP_CLOCKS - 1);

  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t                 state_r, state_nxt_s;
  logic [2:0]             bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]             shift_r, shift_nxt_s;
  logic                   full_r, full_nxt_s;      // 8 bits seen / ACK seen, awaiting the fall
  logic                   rw_r, rw_nxt_s;
  logic                   first_r, first_nxt_s;
  logic [SETUP_CNT_W-1:0] setup_r, setup_nxt_s;
  logic                   scl_r, scl_nxt_s;
  logic                   sda_r, sda_nxt_s;
  logic                   start_r, start_nxt_s;
  logic                   stop_r, stop_nxt_s;
  logic                   rx_stb_r, rx_stb_nxt_s;
  logic                   rx_first_r, rx_first_nxt_s;
  logic [7:0]             rx_data_r, rx_data_nxt_s;
  logic                   tx_req_r, tx_req_nxt_s;
  logic                   busy_r, busy_nxt_s;

  i2c_bus_sync u_sync (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .scl_s      (scl_s),
    .sda_s      (sda_s),
    .scl_rise_s (scl_rise_s),
    .scl_fall_s (scl_fall_s),
    .start_s    (start_s),
    .stop_s     (stop_s)
  );

  // FSM state, datapath and registered pad/host outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      full_r     <= 1'b0;
      rw_r       <= 1'b0;
      first_r    <= 1'b0;
      setup_r    <= '0;
      scl_r      <= 1'b1;
      sda_r      <= 1'b1;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
      rx_stb_r   <= 1'b0;
      rx_first_r <= 1'b0;
      rx_data_r  <= 8'h00;
      tx_req_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      full_r     <= full_nxt_s;
      rw_r       <= rw_nxt_s;
      first_r    <= first_nxt_s;
      setup_r    <= setup_nxt_s;
      scl_r      <= scl_nxt_s;
      sda_r      <= sda_nxt_s;
      start_r    <= start_nxt_s;
      stop_r     <= stop_nxt_s;
      rx_stb_r   <= rx_stb_nxt_s;
      rx_first_r <= rx_first_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
      tx_req_r   <= tx_req_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  // Next-state logic: bus START/STOP override every state, otherwise per-state bit handling
  always_comb begin
    state_nxt_s    = state_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    full_nxt_s     = full_r;
    rw_nxt_s       = rw_r;
    first_nxt_s    = first_r;
    setup_nxt_s    = setup_r;
    scl_nxt_s      = scl_r;
    sda_nxt_s      = sda_r;
    start_nxt_s    = 1'b0;
    stop_nxt_s     = 1'b0;
    rx_stb_nxt_s   = 1'b0;
    rx_first_nxt_s = 1'b0;
    rx_data_nxt_s  = rx_data_r;
    tx_req_nxt_s   = tx_req_r;
    busy_nxt_s     = busy_r;

    if (start_s) begin
      start_nxt_s   = 1'b1;
      bit_cnt_nxt_s = 3'd0;
      full_nxt_s    = 1'b0;
      scl_nxt_s     = 1'b1;
      sda_nxt_s     = 1'b1;
      tx_req_nxt_s  = 1'b0;
      busy_nxt_s    = 1'b0;
      state_nxt_s   = ST_ADDR;
    end else if (stop_s) begin
      stop_nxt_s    = 1'b1;
      full_nxt_s    = 1'b0;
      scl_nxt_s     = 1'b1;
      sda_nxt_s     = 1'b1;
      tx_req_nxt_s  = 1'b0;
      busy_nxt_s    = 1'b0;
      state_nxt_s   = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          scl_nxt_s = 1'b1;
          sda_nxt_s = 1'b1;
        end

        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_nxt_s   = shift_in(shift_r, sda_s);
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            full_nxt_s    = (bit_cnt_r == 3'd7);
          end else if (scl_fall_s && full_r) begin
            full_nxt_s = 1'b0;
            if (shift_r[7:1] == I2C_ADDR) begin
              sda_nxt_s   = 1'b0;
              rw_nxt_s    = shift_r[0];
              state_nxt_s = ST_AACK;
            end else begin
              state_nxt_s = ST_IGNORE;
            end
          end else begin
            full_nxt_s = full_r;
          end
        end

        ST_AACK: begin
          if (scl_fall_s) begin
            sda_nxt_s     = 1'b1;
            busy_nxt_s    = 1'b1;
            bit_cnt_nxt_s = 3'd0;
            full_nxt_s    = 1'b0;
            if (!rw_r) begin
              first_nxt_s = 1'b1;
              state_nxt_s = ST_RXBIT;
            end else begin
              scl_nxt_s    = 1'b0;
              tx_req_nxt_s = 1'b1;
              setup_nxt_s  = '0;
              state_nxt_s  = ST_TXWAIT;
            end
          end else begin
            sda_nxt_s = 1'b0;
          end
        end

        ST_RXBIT: begin
          if (scl_rise_s) begin
            shift_nxt_s   = shift_in(shift_r, sda_s);
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              full_nxt_s     = 1'b1;
              rx_data_nxt_s  = shift_in(shift_r, sda_s);
              rx_stb_nxt_s   = 1'b1;
              rx_first_nxt_s = first_r;
            end else begin
              full_nxt_s = 1'b0;
            end
          end else if (scl_fall_s && full_r) begin
            full_nxt_s  = 1'b0;
            sda_nxt_s   = 1'b0;
            state_nxt_s = ST_RXACK;
          end else begin
            full_nxt_s = full_r;
          end
        end

        ST_RXACK: begin
          if (scl_fall_s) begin
            sda_nxt_s   = 1'b1;
            first_nxt_s = 1'b0;
            state_nxt_s = ST_RXBIT;
          end else begin
            sda_nxt_s = 1'b0;
          end
        end

        ST_TXWAIT: begin
          scl_nxt_s = 1'b0;
          if (tx_req_r) begin
            if (i_tx_stb) begin
              shift_nxt_s  = i_tx_data;
              tx_req_nxt_s = 1'b0;
              sda_nxt_s    = i_tx_data[7];
              setup_nxt_s  = '0;
            end else begin
              tx_req_nxt_s = 1'b1;
            end
          end else if (setup_r == SETUP_LAST) begin
            // Bit 7 has been stable on SDA long enough; let the controller clock it
            scl_nxt_s     = 1'b1;
            bit_cnt_nxt_s = 3'd0;
            full_nxt_s    = 1'b0;
            state_nxt_s   = ST_TXBIT;
          end else begin
            setup_nxt_s = setup_r + 1'b1;
          end
        end

        ST_TXBIT: begin
          if (scl_fall_s) begin
            if (bit_cnt_r == 3'd7) begin
              sda_nxt_s   = 1'b1;
              full_nxt_s  = 1'b0;
              state_nxt_s = ST_TXACK;
            end else begin
              shift_nxt_s   = {shift_r[6:0], 1'b0};
              sda_nxt_s     = shift_r[6];
              bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            sda_nxt_s = sda_r;
          end
        end

        ST_TXACK: begin
          if (scl_rise_s) begin
            if (!sda_s) begin
              full_nxt_s = 1'b1;
            end else begin
              // NAK: controller wants no more data; release the bus
              busy_nxt_s   = 1'b0;
              tx_req_nxt_s = 1'b0;
              state_nxt_s  = ST_IGNORE;
            end
          end else if (scl_fall_s && full_r) begin
            full_nxt_s   = 1'b0;
            scl_nxt_s    = 1'b0;
            tx_req_nxt_s = 1'b1;
            setup_nxt_s  = '0;
            state_nxt_s  = ST_TXWAIT;
          end else begin
            full_nxt_s = full_r;
          end
        end

        ST_IGNORE: begin
          scl_nxt_s    = 1'b1;
          sda_nxt_s    = 1'b1;
          busy_nxt_s   = 1'b0;
          tx_req_nxt_s = 1'b0;
        end

        default: begin
          scl_nxt_s    = 1'b1;
          sda_nxt_s    = 1'b1;
          busy_nxt_s   = 1'b0;
          tx_req_nxt_s = 1'b0;
          state_nxt_s  = ST_IDLE;
        end
      endcase
    end
  end

  assign o_scl      = scl_r;
  assign o_sda      = sda_r;
  assign o_start    = start_r;
  assign o_stop     = stop_r;
  assign o_rx_stb   = rx_stb_r;
  assign o_rx_first = rx_first_r;
  assign o_rx_data  = rx_data_r;
  assign o_tx_req   = tx_req_r;
  assign o_busy     = busy_r;

endmodule

// File: tb/tb_lli2cs.sv
// Directed bench for lli2cs: a bit-banged I2C controller on a wired-AND bus
// drives writes, reads, address mismatch, repeated START and reset mid-read.
module tb_lli2cs;

  localparam int Q     = 8;   // quarter SCL period in i_clk cycles
  localparam int SETUP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1, m_sda = 1'b1;
  logic scl_bus, sda_bus;
  logic o_scl, o_sda, o_start, o_stop, o_rx_stb, o_rx_first, o_tx_req, o_busy;
  logic [7:0] o_rx_data;
  logic i_tx_stb = 1'b0;
  logic [7:0] i_tx_data = 8'h00;

  int pass_cnt = 0, check_cnt = 0;
  int n_start = 0, n_stop = 0, n_rx = 0, n_txreq = 0, n_sda_low = 0, n_busy = 0;
  logic [7:0] rx_log [0:255];
  logic       rxf_log [0:255];
  logic       tx_req_q = 1'b0;

  assign scl_bus = m_scl & o_scl;
  assign sda_bus = m_sda & o_sda;

  always #5 clk = ~clk;

  lli2cs #(.I2C_ADDR(7'h50), .SETUP_CLOCKS(SETUP)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_scl(scl_bus), .i_sda(sda_bus),
    .o_scl(o_scl), .o_sda(o_sda), .o_start(o_start), .o_stop(o_stop),
    .o_rx_stb(o_rx_stb), .o_rx_first(o_rx_first), .o_rx_data(o_rx_data),
    .o_tx_req(o_tx_req), .i_tx_stb(i_tx_stb), .i_tx_data(i_tx_data), .o_busy(o_busy)
  );

  // Event monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (o_start) n_start <= n_start + 1;
    if (o_stop) n_stop <= n_stop + 1;
    if (o_rx_stb) begin
      rx_log[n_rx[7:0]]  <= o_rx_data;
      rxf_log[n_rx[7:0]] <= o_rx_first;
      n_rx <= n_rx + 1;
    end
    tx_req_q <= o_tx_req;
    if (o_tx_req && !tx_req_q) n_txreq <= n_txreq + 1;
    if (!o_sda) n_sda_low <= n_sda_low + 1;
    if (o_busy) n_busy <= n_busy + 1;
  end

  task automatic wait_q;
    repeat (Q) @(negedge clk);
  endtask

  task automatic wait_scl_high;
    for (int i = 0; i < 2000 && scl_bus !== 1'b1; i++) @(negedge clk);
    if (scl_bus !== 1'b1) begin
      check_cnt++;
      $display("FAIL scl_timeout: scl=%b expected 1 within 2000 cycles", scl_bus);
    end
  endtask

  task automatic m_start;
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; wait_scl_high; wait_q;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic m_stop;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b1; wait_scl_high; wait_q;
    m_sda = 1'b1; wait_q;
  endtask

  task automatic m_bit_write(input logic b);
    m_sda = b; wait_q;
    m_scl = 1'b1; wait_scl_high; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic m_bit_read(output logic b);
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; wait_scl_high; wait_q;
    b = sda_bus;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit_write(d[i]);
    m_bit_read(ack);
  endtask

  task automatic m_read_byte(output logic [7:0] d, input logic nak);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_bit_read(b);
      d = {d[6:0], b};
    end
    m_bit_write(nak);
  endtask

  task automatic wait_txreq;
    for (int i = 0; i < 500 && o_tx_req !== 1'b1; i++) @(negedge clk);
    if (o_tx_req !== 1'b1) begin
      check_cnt++;
      $display("FAIL tx_req_timeout: o_tx_req=%b expected 1 within 500 cycles", o_tx_req);
    end
  endtask

  task automatic serve(input logic [7:0] d);
    wait_txreq;
    repeat (2) @(negedge clk);
    i_tx_stb = 1'b1; i_tx_data = d;
    @(negedge clk);
    i_tx_stb = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if ({o_scl, o_sda} !== 2'b11) $display("FAIL rst_lines: got %b expected 11", {o_scl, o_sda}); else pass_cnt++;
    check_cnt++; if ({o_start, o_stop, o_rx_stb, o_rx_first, o_tx_req, o_busy} !== 6'b0) $display("FAIL rst_flags: got %b expected 000000", {o_start, o_stop, o_rx_stb, o_rx_first, o_tx_req, o_busy}); else pass_cnt++;
    check_cnt++; if (o_rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h expected 00", o_rx_data); else pass_cnt++;
    check_cnt++; if (dut.state_r !== lli2cs_pkg::ST_IDLE) $display("FAIL rst_state: got %0d expected 0", dut.state_r); else pass_cnt++;
    // Stray host strobe with no request outstanding must be ignored
    i_tx_stb = 1'b1; i_tx_data = 8'h00; @(negedge clk); i_tx_stb = 1'b0;
    repeat (2) @(negedge clk);
    check_cnt++; if ({o_scl, o_sda, o_tx_req} !== 3'b110) $display("FAIL stray_stb: got %b expected 110", {o_scl, o_sda, o_tx_req}); else pass_cnt++;
  endtask

  task automatic test_write;
    int s0, p0, r0;
    logic a0, a1, a2;
    s0 = n_start; p0 = n_stop; r0 = n_rx;
    m_start;
    m_write_byte(8'hA0, a0);
    check_cnt++; if (o_busy !== 1'b1) $display("FAIL wr_busy: got %b expected 1", o_busy); else pass_cnt++;
    m_write_byte(8'h12, a1);
    m_write_byte(8'h34, a2);
    m_stop;
    repeat (4) @(negedge clk);
    check_cnt++; if ({a0, a1, a2} !== 3'b000) $display("FAIL wr_acks: got %b expected 000", {a0, a1, a2}); else pass_cnt++;
    check_cnt++; if ((n_start - s0) !== 1 || (n_stop - p0) !== 1) $display("FAIL wr_start_stop: got %0d/%0d expected 1/1", n_start - s0, n_stop - p0); else pass_cnt++;
    check_cnt++; if ((n_rx - r0) !== 2) $display("FAIL wr_rx_count: got %0d expected 2", n_rx - r0); else pass_cnt++;
    check_cnt++; if ({rx_log[r0], rxf_log[r0]} !== {8'h12, 1'b1}) $display("FAIL wr_byte0: got %h/%b expected 12/1", rx_log[r0], rxf_log[r0]); else pass_cnt++;
    check_cnt++; if ({rx_log[r0+1], rxf_log[r0+1]} !== {8'h34, 1'b0}) $display("FAIL wr_byte1: got %h/%b expected 34/0", rx_log[r0+1], rxf_log[r0+1]); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b0) $display("FAIL wr_busy_end: got %b expected 0", o_busy); else pass_cnt++;
  endtask

  task automatic test_mismatch;
    int l0, r0, b0;
    logic a0, a1;
    l0 = n_sda_low; r0 = n_rx; b0 = n_busy;
    m_start;
    m_write_byte(8'hA2, a0);
    m_write_byte(8'h55, a1);
    m_stop;
    repeat (4) @(negedge clk);
    check_cnt++; if ({a0, a1} !== 2'b11) $display("FAIL mm_nak: got %b expected 11", {a0, a1}); else pass_cnt++;
    check_cnt++; if ((n_sda_low - l0) !== 0) $display("FAIL mm_sda_low: got %0d cycles expected 0", n_sda_low - l0); else pass_cnt++;
    check_cnt++; if ((n_rx - r0) !== 0) $display("FAIL mm_rx: got %0d expected 0", n_rx - r0); else pass_cnt++;
    check_cnt++; if ((n_busy - b0) !== 0) $display("FAIL mm_busy: got %0d cycles expected 0", n_busy - b0); else pass_cnt++;
  endtask

  task automatic test_read_stretch;
    int t0, low;
    logic a0;
    logic [7:0] d;
    t0 = n_txreq;
    m_start;
    m_write_byte(8'hA1, a0);
    check_cnt++; if (a0 !== 1'b0) $display("FAIL rd_addr_ack: got %b expected 0", a0); else pass_cnt++;
    wait_txreq;
    repeat (20) @(negedge clk);
    check_cnt++; if ({o_scl, scl_bus, o_tx_req} !== 3'b001) $display("FAIL rd_stretch: got %b expected 001", {o_scl, scl_bus, o_tx_req}); else pass_cnt++;
    i_tx_stb = 1'b1; i_tx_data = 8'hC5;
    @(negedge clk);
    i_tx_stb = 1'b0;
    check_cnt++; if ({o_sda, o_tx_req} !== 2'b10) $display("FAIL rd_bit7_setup: got %b expected 10", {o_sda, o_tx_req}); else pass_cnt++;
    low = 0;
    while (o_scl === 1'b0 && low < 100) begin
      low++;
      @(negedge clk);
    end
    check_cnt++; if (low !== SETUP) $display("FAIL rd_setup_clocks: got %0d expected %0d", low, SETUP); else pass_cnt++;
    m_read_byte(d, 1'b1);
    check_cnt++; if (d !== 8'hC5) $display("FAIL rd_data: got %h expected c5", d); else pass_cnt++;
    m_stop;
    repeat (4) @(negedge clk);
    check_cnt++; if ((n_txreq - t0) !== 1) $display("FAIL rd_txreq_count: got %0d expected 1", n_txreq - t0); else pass_cnt++;
  endtask

  task automatic test_read_end;
    int t0;
    logic a0;
    logic [7:0] d1, d2;
    t0 = n_txreq;
    m_start;
    m_write_byte(8'hA1, a0);
    serve(8'h5A);
    m_read_byte(d1, 1'b0);
    serve(8'h3C);
    m_read_byte(d2, 1'b1);
    check_cnt++; if ({o_sda, o_scl, o_busy, o_tx_req} !== 4'b1100) $display("FAIL re_after_nak: got %b expected 1100", {o_sda, o_scl, o_busy, o_tx_req}); else pass_cnt++;
    m_stop;
    repeat (4) @(negedge clk);
    check_cnt++; if ({d1, d2} !== 16'h5A3C) $display("FAIL re_data: got %h expected 5a3c", {d1, d2}); else pass_cnt++;
    check_cnt++; if ((n_txreq - t0) !== 2) $display("FAIL re_txreq_count: got %0d expected 2", n_txreq - t0); else pass_cnt++;
    check_cnt++; if (dut.state_r !== lli2cs_pkg::ST_IDLE) $display("FAIL re_idle: got %0d expected 0", dut.state_r); else pass_cnt++;
  endtask

  task automatic test_repeated_start;
    int s0, r0;
    logic a0, a1, a2;
    logic [7:0] d;
    s0 = n_start; r0 = n_rx;
    m_start;
    m_write_byte(8'hA0, a0);
    m_write_byte(8'h07, a1);
    m_start;
    m_write_byte(8'hA1, a2);
    wait_txreq;
    check_cnt++; if ({a0, a1, a2} !== 3'b000) $display("FAIL sr_acks: got %b expected 000", {a0, a1, a2}); else pass_cnt++;
    check_cnt++; if ((n_start - s0) !== 2) $display("FAIL sr_start_count: got %0d expected 2", n_start - s0); else pass_cnt++;
    check_cnt++; if ((n_rx - r0) !== 1) $display("FAIL sr_rx_count: got %0d expected 1", n_rx - r0); else pass_cnt++;
    check_cnt++; if ({rx_log[r0], rxf_log[r0]} !== {8'h07, 1'b1}) $display("FAIL sr_rx_byte: got %h/%b expected 07/1", rx_log[r0], rxf_log[r0]); else pass_cnt++;
    check_cnt++; if ({o_tx_req, o_busy, o_scl} !== 3'b110) $display("FAIL sr_tx_req: got %b expected 110", {o_tx_req, o_busy, o_scl}); else pass_cnt++;
    serve(8'h81);
    m_read_byte(d, 1'b1);
    check_cnt++; if (d !== 8'h81) $display("FAIL sr_read: got %h expected 81", d); else pass_cnt++;
    m_stop;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midread;
    int r0;
    logic a0, a1, a2;
    m_start;
    m_write_byte(8'hA1, a0);
    wait_txreq;
    repeat (3) @(negedge clk);
    check_cnt++; if (o_scl !== 1'b0) $display("FAIL mr_stretch: got %b expected 0", o_scl); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++; if ({o_scl, o_sda} !== 2'b11) $display("FAIL mr_lines: got %b expected 11", {o_scl, o_sda}); else pass_cnt++;
    check_cnt++; if ({o_start, o_stop, o_rx_stb, o_tx_req, o_busy, o_rx_data} !== 13'h0) $display("FAIL mr_outputs: got %h expected 0", {o_start, o_stop, o_rx_stb, o_tx_req, o_busy, o_rx_data}); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_scl = 1'b1; m_sda = 1'b1;
    wait_q; wait_q;
    r0 = n_rx;
    m_start;
    m_write_byte(8'hA0, a1);
    m_write_byte(8'h99, a2);
    m_stop;
    repeat (4) @(negedge clk);
    check_cnt++; if ({a1, a2} !== 2'b00) $display("FAIL mr_acks: got %b expected 00", {a1, a2}); else pass_cnt++;
    check_cnt++; if ((n_rx - r0) !== 1 || rx_log[r0] !== 8'h99) $display("FAIL mr_rx: got %0d/%h expected 1/99", n_rx - r0, rx_log[r0]); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_mismatch;
    test_read_stretch;
    test_read_end;
    test_repeated_start;
    test_reset_midread;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
